// File: rtl/mem_burst_master.sv
// Burst controller for a single-port synchronous RAM: accepts read/write burst
// commands and walks wrapping addresses, hiding the RAM's one-cycle read latency.
module mem_burst_master #(
    parameter int DW   = 8,
    parameter int AW   = 5,
    parameter int LENW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_wr,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [LENW-1:0] cmd_len,
    input  logic            wdata_valid,
    output logic            wdata_ready,
    input  logic [DW-1:0]   wdata,
    output logic            rdata_valid,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic            done,
    output logic            mem_wr_re,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0]   ADDR_ONE = AW'(1);
    localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);
    localparam logic [LENW-1:0] LEN_ZERO = LENW'(0);

    state_t          state_q, state_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [LENW-1:0] remaining_q, remaining_d;
    logic            rd_pend_q, rd_pend_d;
    logic            beat_s;

    assign beat_s = (state_q == S_WRITE) && wdata_valid;

    // Next-state, address walk and beat counting
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        rd_pend_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    if (cmd_len == LEN_ZERO) begin
                        state_d = S_DONE;
                    end else if (cmd_wr) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (wdata_valid) begin
                    cur_addr_d  = cur_addr_q + ADDR_ONE;
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WRITE;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_READ: begin
                // every READ cycle issues a RAM read whose data returns next cycle
                cur_addr_d  = cur_addr_q + ADDR_ONE;
                remaining_d = remaining_q - LEN_ONE;
                rd_pend_d   = 1'b1;
                if (remaining_q == LEN_ONE) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    // rst gates cmd_ready so no handshake can be seen while reset is held
    assign cmd_ready   = (state_q == S_IDLE) && !rst;
    assign wdata_ready = (state_q == S_WRITE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign mem_wr_re   = beat_s;
    assign mem_addr    = cur_addr_q;
    assign mem_din     = beat_s ? wdata : '0;
    assign rdata_valid = rd_pend_q;
    assign rdata       = mem_dout;

endmodule

// File: tb/tb_mem_burst_master.sv
// Randomized scoreboard bench for mem_burst_master with a behavioural RAM and
// a word-array reference memory.
module tb_mem_burst_master;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int LENW  = 6;
    localparam int DEPTH = 32;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_wr;
    logic [AW-1:0]   cmd_addr;
    logic [LENW-1:0] cmd_len;
    logic            wdata_valid;
    logic            wdata_ready;
    logic [DW-1:0]   wdata;
    logic            rdata_valid;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            done;
    logic            mem_wr_re;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   mem_dout;

    mem_burst_master #(.DW(DW), .AW(AW), .LENW(LENW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata),
        .busy(busy), .done(done),
        .mem_wr_re(mem_wr_re), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_wr_re) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int rd_seen = 0;
    int done_seen = 0;
    logic [DW-1:0]    ref_mem [DEPTH];
    logic [DW-1:0]    wq [$];
    logic [AW+DW-1:0] exp_wr [$];
    logic [AW+DW-1:0] exp_rd [$];
    logic [AW-1:0]    prev_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected beats whenever the DUT presents one
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr_re) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
                    chk("wr_data", 32'(mem_din), 32'(e[DW-1:0]));
                end
            end else begin
                chk("din_idle_zero", 32'(mem_din), 32'd0);
            end
            if (rdata_valid) begin
                rd_seen++;
                if (exp_rd.size() == 0) begin
                    chk("unexpected_rdata", 32'(rdata), 32'hFFFF_FFFF);
                end else begin
                    logic [AW+DW-1:0] e;
                    e = exp_rd.pop_front();
                    chk("rd_addr", 32'(prev_addr), 32'(e[AW+DW-1:DW]));
                    chk("rd_data", 32'(rdata), 32'(e[DW-1:0]));
                end
            end
            if (done) done_seen++;
        end
        prev_addr <= mem_addr;
    end

    // Handshake one command and push its expected beats from the reference memory
    task automatic issue(input bit wr, input int addr, input int len);
        int w = 0;
        while (!cmd_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = AW'(addr);
        cmd_len   = LENW'(len);
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = AW'((addr + i) % DEPTH);
            if (wr) begin
                exp_wr.push_back({a, wq[i]});
                ref_mem[a] = wq[i];
            end else begin
                exp_rd.push_back({a, ref_mem[a]});
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_len   = LENW'($urandom);
    endtask

    // mode 0: continuous wdata_valid, 1: alternating 1,0,1,..., 2: random gaps
    task automatic run(input bit wr, input int addr, input int len, input int mode);
        int cyc = 1, sent = 0, gaps = 0, slot = 0, done_cyc = 0, ndone = 0;
        bit done_rv = 1'b0;
        bit v;
        issue(wr, addr, len);
        while (1) begin
            if (done) begin
                if (done_cyc == 0) done_cyc = cyc;
                done_rv = rdata_valid;
                ndone++;
            end
            if (cmd_ready || cyc > 4 * len + 64) break;
            if (wr && wdata_ready && sent < len) begin
                if (mode == 0)      v = 1'b1;
                else if (mode == 1) v = (slot % 2 == 0);
                else                v = ($urandom_range(0, 3) != 0);
                slot++;
                wdata_valid = v;
                wdata = v ? wq[sent] : DW'($urandom);
                if (v) sent++;
                else   gaps++;
            end else begin
                wdata_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wdata_valid = 1'b0;
        chk("ready_latency", 32'(cyc), 32'(len + gaps + 2));
        chk("done_cycle", 32'(done_cyc), 32'(len + gaps + 1));
        chk("done_count", 32'(ndone), 32'd1);
        if (!wr && len > 0) chk("done_with_last_rdata", 32'(done_rv), 32'd1);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, dbase, w;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        @(posedge clk); @(posedge clk); #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_wr_re", 32'(mem_wr_re), 32'd0);
        chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        wq.delete();
        for (int i = 0; i < 32; i++) wq.push_back(DW'(3 * i));
        run(1'b1, 0, 32, 0);
        run(1'b0, 30, 4, 0);

        wq.delete();
        wq.push_back(8'hA1); wq.push_back(8'hB2); wq.push_back(8'hC3);
        run(1'b1, 5, 3, 1);
        run(1'b0, 5, 3, 0);

        run(1'b0, 7, 0, 0);
        run(1'b1, 9, 0, 0);

        for (int n = 0; n < 24; n++) begin
            int len;
            len = $urandom_range(0, 40);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back(DW'($urandom));
            run(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), len, $urandom_range(0, 2));
        end

        base  = rd_seen;
        dbase = done_seen;
        issue(1'b0, 10, 8);
        w = 0;
        while (rd_seen < base + 2 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("abort_two_beats_seen", 32'(rd_seen - base), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("abort_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_wr_re", 32'(mem_wr_re), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("abort_no_done", 32'(done_seen - dbase), 32'd0);
        exp_rd.delete();
        rst = 1'b0;
        #1;

        wq.delete();
        wq.push_back(8'h5A);
        run(1'b1, 2, 1, 0);
        run(1'b0, 2, 1, 0);
        run(1'b0, 0, 32, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
